ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Controller that turns a `DualPortRam` instance (1-cycle registered read, write-before-nothing semantics) into a show-ahead valid/ready FIFO. It owns the write and read pointers, drives the RAM's write and read ports, and hides the RAM read latency with a single output stage, so a consumer sees data and `outValid` together. It sits between any streaming producer/consumer pair (e.g. fetch buffer, UART/debug queues) and a `DualPortRam` of matching `DATA_WIDTH`/`ADDR_WIDTH`.

## Interface
- `DATA_WIDTH`, 32, word width; must match the attached RAM.
- `ADDR_WIDTH`, 5, RAM address width; RAM depth `2**ADDR_WIDTH`.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of FIFO contents.
- `inValid` input 1: producer has a word.
- `inReady` output 1: controller can accept a word this cycle.
- `inData` input `DATA_WIDTH`: producer word.
- `outValid` output 1: `outData` holds the head word.
- `outReady` input 1: consumer takes the head word this cycle.
- `outData` output `DATA_WIDTH`: head word.
- `ramWe` output 1: to RAM `we`.
- `ramWAddr` output `ADDR_WIDTH`: to RAM `wAddr`.
- `ramRAddr` output `ADDR_WIDTH`: to RAM `rAddr`.
- `ramDataIn` output `DATA_WIDTH`: to RAM `dataIn`.
- `ramQ` input `DATA_WIDTH`: from RAM `q`.
- `level` output `ADDR_WIDTH+2`: occupancy (only with `RAM_FIFO_LEVEL_EN`).

## Operation
- Pointers `wrPtr`, `rdPtr`: `ADDR_WIDTH+1` bits, wrap modulo `2**(ADDR_WIDTH+1)`; `ramCount = wrPtr - rdPtr` (same width), range 0..`2**ADDR_WIDTH`.
- `inReady = !flush && ramCount != 2**ADDR_WIDTH`. Combinational from registered state only; a same-cycle pop does not free a slot.
- Push (`inValid && inReady`): `ramWe=1`, `ramWAddr=wrPtr[ADDR_WIDTH-1:0]`, `ramDataIn=inData`, `wrPtr++`. `ramDataIn`/`ramWAddr` follow `inData`/`wrPtr` when not pushing; `ramWe=0`.
- Fetch condition: `!flush && ramCount != 0 && (!outValid || outReady)`. `ramRAddr = rdPtr[ADDR_WIDTH-1:0]` always; on fetch, `rdPtr++`, `outValid<=1`, `selQ<=1`.
- Pop without fetch (`outValid && outReady`, `ramCount==0`): `outValid<=0`.
- Output stage: `outData = selQ ? ramQ : holdReg`. Cycle after a fetch, `holdReg<=ramQ` and `selQ<=0` unless another fetch occurs (then `selQ` stays 1). `holdReg` guarantees `outData` stable while stalled, even after the freed slot is overwritten.
- No RAM read/write address collision is possible: equal indices imply `ramCount` 0 (no fetch) or full (no push).
- `flush` (highest priority, synchronous): `wrPtr=rdPtr=0`, `outValid=0`, `selQ=0`; no push accepted, no fetch issued that cycle. RAM contents untouched.
- Total capacity `2**ADDR_WIDTH + 1` words (RAM plus output stage).

## Timing
- Reset values: `wrPtr=rdPtr=0`, `outValid=0`, `selQ=0`, `holdReg=0` → `outData=0`, `inReady=1`, `ramWe=0`, `ramRAddr=0`, `ramWAddr=0`, `level=0`.
- Empty-FIFO latency: word accepted at edge E is presented with `outValid=1` after edge E+1 (one bubble cycle).
- Sustained throughput: one push and one pop per cycle once the output stage is primed.
- Stall: while `outValid && !outReady`, `outData`/`outValid` hold; RAM keeps filling until `inReady=0`.
- `rst` asserted mid-transfer: all state cleared immediately, independent of `clk`; in-flight words lost.

## Configuration
- `RAM_FIFO_LEVEL_EN` defined: `level` port present, `level = ramCount + outValid`, registered-state combinational, range 0..`2**ADDR_WIDTH+1`.
- Undefined: `level` port and its logic absent; all other behaviour identical.

## Test plan
- Reset then idle: `outValid=0`, `outData=0`, `inReady=1`, `ramWe=0` for 10 cycles; assert `rst` asynchronously mid-cycle → outputs clear before next edge.
- Single push 0xA5A5A5A5 at edge E, `outReady=0`: `outValid=1`, `outData=0xA5A5A5A5` after E+1 and held for 20 cycles while RAM slot 0 is rewritten with 0xFFFFFFFF.
- Fill with ADDR_WIDTH=5, `outReady=0`: 33 words accepted (0..32), `inReady=0` after the 33rd; `level=33` with macro; one pop re-raises `inReady` next cycle.
- Streaming: 1000 incrementing words, `inValid=outReady=1` continuously → output order preserved, one word per cycle after 2-cycle start-up, pointer wrap exercised.
- Random `inValid`/`outReady` (50%) for 5000 cycles vs. scoreboard queue → no loss, duplication or reordering.
- `flush` with 10 words queued: next cycle `outValid=0`, `inReady=1`, `level=0`; push 0x1234 after flush returns 0x1234, not stale data.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead valid/ready FIFO around a 1-cycle registered-read DualPortRam; `RAM_FIFO_LEVEL_EN adds the level port.
// Latency: a word pushed into an empty FIFO is on outData with outValid two edges later; one word/cycle sustained.
// Backpressure: inReady falls when the RAM is full; the output stage holds outData/outValid while outReady is low.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [DATA_WIDTH-1:0] inData,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [DATA_WIDTH-1:0] outData,
   output logic                  ramWe,
   output logic [ADDR_WIDTH-1:0] ramWAddr,
   output logic [ADDR_WIDTH-1:0] ramRAddr,
   output logic [DATA_WIDTH-1:0] ramDataIn,
   input  logic [DATA_WIDTH-1:0] ramQ
`ifdef RAM_FIFO_LEVEL_EN
   ,
   output logic [ADDR_WIDTH+1:0] level
`endif
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         ram_count;
   logic                  out_valid;
   logic                  sel_q;
   logic                  push;
   logic                  fetch;
   logic [DATA_WIDTH-1:0] hold_reg;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign ram_count = wr_ptr - rd_ptr;
   assign inReady   = !flush && (ram_count != DEPTH);
   assign push      = inValid && inReady;
   assign fetch     = !flush && (ram_count != '0) && (!out_valid || outReady);

   assign ramWe     = push;
   assign ramWAddr  = wr_ptr[ADDR_WIDTH-1:0];
   assign ramDataIn = inData;
   assign ramRAddr  = rd_ptr[ADDR_WIDTH-1:0];

   // RAM q is only valid the cycle after a fetch; afterwards the copy in hold_reg
   // keeps the head stable even once its slot is overwritten.
   assign outValid  = out_valid;
   assign outData   = sel_q ? ramQ : hold_reg;

`ifdef RAM_FIFO_LEVEL_EN
   assign level = (ADDR_WIDTH+2)'(ram_count) + (ADDR_WIDTH+2)'(out_valid);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         sel_q     <= 1'b0;
         hold_reg  <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         sel_q     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (fetch) begin
            rd_ptr    <= rd_ptr + PW'(1);
            out_valid <= 1'b1;
         end else if (outReady) begin
            out_valid <= 1'b0;
         end
         sel_q <= fetch;
         if (sel_q) begin
            hold_reg <= ramQ;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and randomized bench for ram_fifo_ctrl with a behavioural 1-cycle-read dual-port RAM attached.
module tb_ram_fifo_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          inValid;
   logic          inReady;
   logic [DW-1:0] inData;
   logic          outValid;
   logic          outReady;
   logic [DW-1:0] outData;
   logic          ramWe;
   logic [AW-1:0] ramWAddr;
   logic [AW-1:0] ramRAddr;
   logic [DW-1:0] ramDataIn;
   logic [DW-1:0] ramQ;
`ifdef RAM_FIFO_LEVEL_EN
   logic [AW+1:0] level;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] q [$];
   int            checks   = 0;
   int            failures = 0;

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .inValid   (inValid),
      .inReady   (inReady),
      .inData    (inData),
      .outValid  (outValid),
      .outReady  (outReady),
      .outData   (outData),
      .ramWe     (ramWe),
      .ramWAddr  (ramWAddr),
      .ramRAddr  (ramRAddr),
      .ramDataIn (ramDataIn),
      .ramQ      (ramQ)
`ifdef RAM_FIFO_LEVEL_EN
      ,
      .level     (level)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ramWe) mem[ramWAddr] <= ramDataIn;
      ramQ <= mem[ramRAddr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_level(input string tag, input int exp);
`ifdef RAM_FIFO_LEVEL_EN
      check(tag, 64'(level), 64'(exp));
`else
      if (exp < 0) $display("negative level request %s", tag);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int accepted;
      int idx;
      int used;
      int n_in;
      int n_out;
      int first_pop;
      int last_pop;
      logic [DW-1:0] head;

      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; inData = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int c = 0; c < 10; c++) begin
         #1;
         check("idle_out_valid", 64'(outValid), 64'(0));
         check("idle_out_data", 64'(outData), 64'(0));
         check("idle_in_ready", 64'(inReady), 64'(1));
         check("idle_ram_we", 64'(ramWe), 64'(0));
         tick();
      end
      check("idle_raddr", 64'(ramRAddr), 64'(0));
      check("idle_waddr", 64'(ramWAddr), 64'(0));
      check_level("idle_level", 0);

      // Asynchronous reset mid-cycle with a word presented
      inValid = 1'b1; inData = 32'h11;
      tick();
      inValid = 1'b0;
      tick();
      #1;
      check("pre_rst_out_valid", 64'(outValid), 64'(1));
      check("pre_rst_out_data", 64'(outData), 64'h11);
      #1 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(outValid), 64'(0));
      check("arst_out_data", 64'(outData), 64'(0));
      check("arst_in_ready", 64'(inReady), 64'(1));
      check("arst_waddr", 64'(ramWAddr), 64'(0));
      check_level("arst_level", 0);
      #1 rst = 1'b0;
      tick();

      // Single push, stalled consumer, then fill the RAM behind it
      inValid = 1'b1; inData = 32'hA5A5A5A5;
      #1;
      check("push_ram_we", 64'(ramWe), 64'(1));
      check("push_waddr", 64'(ramWAddr), 64'(0));
      check("push_ram_din", 64'(ramDataIn), 64'hA5A5A5A5);
      tick();
      inValid = 1'b0;
      #1;
      check("bubble_out_valid", 64'(outValid), 64'(0));
      tick();
      #1;
      check("first_out_valid", 64'(outValid), 64'(1));
      check("first_out_data", 64'(outData), 64'hA5A5A5A5);
      check_level("first_level", 1);
      accepted = 0;
      for (int c = 0; c < 34; c++) begin
         inValid = 1'b1;
         inData  = (accepted == 31) ? 32'hFFFFFFFF : 32'h100 + 32'(accepted);
         #1;
         check("stall_out_valid", 64'(outValid), 64'(1));
         check("stall_out_data", 64'(outData), 64'hA5A5A5A5);
         if (inReady) accepted++;
         tick();
      end
      inValid = 1'b0;
      #1;
      check("fill_accepted", 64'(accepted), 64'(32));
      check("fill_in_ready", 64'(inReady), 64'(0));
      check("fill_held_data", 64'(outData), 64'hA5A5A5A5);
      check_level("fill_level", 33);

      // One pop frees a slot only from the next cycle
      outReady = 1'b1;
      #1;
      check("pop_same_cycle_in_ready", 64'(inReady), 64'(0));
      tick();
      outReady = 1'b0;
      #1;
      check("pop_in_ready", 64'(inReady), 64'(1));
      check("pop_out_valid", 64'(outValid), 64'(1));
      check("pop_next_data", 64'(outData), 64'h100);
      check_level("pop_level", 32);

      // Drain at full rate, order preserved
      idx = 0; used = 0;
      outReady = 1'b1;
      for (int c = 0; c < 40 && idx < 32; c++) begin
         #1;
         if (outValid) begin
            check("drain_data", 64'(outData), (idx < 31) ? 64'(32'h100 + 32'(idx)) : 64'hFFFFFFFF);
            idx++;
         end
         used++;
         tick();
      end
      outReady = 1'b0;
      #1;
      check("drain_count", 64'(idx), 64'(32));
      check("drain_cycles", 64'(used), 64'(32));
      check("drain_out_valid", 64'(outValid), 64'(0));

      // Flush with ten words queued
      for (int i = 0; i < 10; i++) begin
         inValid = 1'b1; inData = 32'h200 + 32'(i);
         tick();
      end
      inValid = 1'b1; inData = 32'hDEAD; flush = 1'b1;
      #1;
      check("flush_in_ready", 64'(inReady), 64'(0));
      check("flush_ram_we", 64'(ramWe), 64'(0));
      tick();
      flush = 1'b0; inValid = 1'b0;
      #1;
      check("post_flush_out_valid", 64'(outValid), 64'(0));
      check("post_flush_in_ready", 64'(inReady), 64'(1));
      check("post_flush_raddr", 64'(ramRAddr), 64'(0));
      check("post_flush_waddr", 64'(ramWAddr), 64'(0));
      check_level("post_flush_level", 0);
      inValid = 1'b1; inData = 32'h1234;
      tick();
      inValid = 1'b0;
      tick();
      #1;
      check("post_flush_valid", 64'(outValid), 64'(1));
      check("post_flush_data", 64'(outData), 64'h1234);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      #1;
      check("post_flush_empty", 64'(outValid), 64'(0));

      // Streaming 1000 words
      n_in = 0; n_out = 0; first_pop = -1; last_pop = -1;
      for (int c = 0; c < 1100 && n_out < 1000; c++) begin
         inValid  = (n_in < 1000);
         inData   = 32'(n_in);
         outReady = 1'b1;
         #1;
         if (outValid && outReady) begin
            check("stream_data", 64'(outData), 64'(n_out));
            if (n_out == 0) first_pop = c;
            last_pop = c;
            n_out++;
         end
         if (inValid && inReady) n_in++;
         tick();
      end
      inValid = 1'b0; outReady = 1'b0;
      check("stream_count", 64'(n_out), 64'(1000));
      check("stream_first_pop", 64'(first_pop), 64'(2));
      check("stream_span", 64'(last_pop - first_pop), 64'(999));

      // Random handshakes against a scoreboard queue
      q.delete();
      for (int c = 0; c < 5000; c++) begin
         inValid  = 1'($urandom_range(0, 1));
         outReady = 1'($urandom_range(0, 1));
         inData   = $urandom;
         #1;
         check_level("rand_level", q.size());
         if (outValid && outReady) begin
            check("rand_q_nonempty", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
               head = q.pop_front();
               check("rand_data", 64'(outData), 64'(head));
            end
         end
         if (inValid && inReady) q.push_back(inData);
         tick();
      end
      inValid = 1'b0; outReady = 1'b1;
      for (int c = 0; c < 100 && q.size() > 0; c++) begin
         #1;
         if (outValid) begin
            head = q.pop_front();
            check("rand_drain_data", 64'(outData), 64'(head));
         end
         tick();
      end
      outReady = 1'b0;
      #1;
      check("rand_drain_left", 64'(q.size()), 64'(0));
      check("rand_drain_valid", 64'(outValid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
